// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants and requester-select encoding for the writeback controller.
package regfile_wb_ctrl_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_ALU  = 2'd1,
    REQ_LSU  = 2'd2
  } req_sel_e;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Issue, writeback and register-file port bundle of the writeback controller.
interface regfile_wb_ctrl_if #(parameter int XLEN = 32);
  logic            Iss_Valid;
  logic [4:0]      Iss_Rs1;
  logic [4:0]      Iss_Rs2;
  logic [4:0]      Iss_Rd;
  logic            Iss_Rd_En;
  logic            Iss_Stall;
  logic            Reg_Rd;
  logic            Alu_Wb_Valid;
  logic            Lsu_Wb_Valid;
  logic [4:0]      Alu_Wb_Rd;
  logic [4:0]      Lsu_Wb_Rd;
  logic [XLEN-1:0] Alu_Wb_Data;
  logic [XLEN-1:0] Lsu_Wb_Data;
  logic            Alu_Wb_Ready;
  logic            Lsu_Wb_Ready;
  logic            Reg_Wr;
  logic [4:0]      Rd_Wr;
  logic [XLEN-1:0] Rd_In;
  logic            Wb_Err;

  modport master (
    output Iss_Valid, Iss_Rs1, Iss_Rs2, Iss_Rd, Iss_Rd_En,
    output Alu_Wb_Valid, Lsu_Wb_Valid, Alu_Wb_Rd, Lsu_Wb_Rd, Alu_Wb_Data, Lsu_Wb_Data,
    input  Iss_Stall, Reg_Rd, Alu_Wb_Ready, Lsu_Wb_Ready, Reg_Wr, Rd_Wr, Rd_In, Wb_Err
  );

  modport slave (
    input  Iss_Valid, Iss_Rs1, Iss_Rs2, Iss_Rd, Iss_Rd_En,
    input  Alu_Wb_Valid, Lsu_Wb_Valid, Alu_Wb_Rd, Lsu_Wb_Rd, Alu_Wb_Data, Lsu_Wb_Data,
    output Iss_Stall, Reg_Rd, Alu_Wb_Ready, Lsu_Wb_Ready, Reg_Wr, Rd_Wr, Rd_In, Wb_Err
  );
endinterface

// File: rtl/regfile_wb_ctrl_scoreboard.sv
// Pending-write mask for the integer register file with RAW/WAW hazard lookup.
module regfile_scoreboard
  import regfile_wb_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [REG_IDX_W-1:0] rs1_i,
  input  logic [REG_IDX_W-1:0] rs2_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic                 rd_en_i,
  input  logic                 set_en_i,
  input  logic [REG_IDX_W-1:0] set_idx_i,
  input  logic                 clr_en_i,
  input  logic [REG_IDX_W-1:0] clr_idx_i,
  output logic                 stall_o,
  output logic                 clr_was_pend_o
);
  logic [NUM_REGS-1:0] pend_q, pend_d;

  assign stall_o = valid_i & (pend_q[rs1_i] | pend_q[rs2_i] | (rd_en_i & pend_q[rd_i]));
  assign clr_was_pend_o = pend_q[clr_idx_i];

  // Set is applied after clear so a same-index collision leaves the bit pending.
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
    if (set_en_i) pend_d[set_idx_i] = 1'b1;
    pend_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback arbiter (LSU priority with ALU starvation guard) and issue hazard gate.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3
) (
  input logic              CLK,
  input logic              rst,
  regfile_wb_ctrl_if.slave bus
);
  req_sel_e             sel;
  logic [2:0]           starve_q, starve_d;
  logic [REG_IDX_W-1:0] win_rd;
  logic [XLEN-1:0]      win_data;
  logic                 reg_wr_q, reg_wr_d;
  logic [REG_IDX_W-1:0] rd_wr_q, rd_wr_d;
  logic [XLEN-1:0]      rd_in_q, rd_in_d;
  logic                 wb_err_q, wb_err_d;
  logic                 iss_stall, iss_set, clr_was_pend;

  assign iss_set = bus.Iss_Valid & ~iss_stall & bus.Iss_Rd_En & (bus.Iss_Rd != ZERO_REG);

  regfile_scoreboard u_sb (
    .clk            (CLK),
    .rst            (rst),
    .valid_i        (bus.Iss_Valid),
    .rs1_i          (bus.Iss_Rs1),
    .rs2_i          (bus.Iss_Rs2),
    .rd_i           (bus.Iss_Rd),
    .rd_en_i        (bus.Iss_Rd_En),
    .set_en_i       (iss_set),
    .set_idx_i      (bus.Iss_Rd),
    .clr_en_i       (reg_wr_q),
    .clr_idx_i      (rd_wr_q),
    .stall_o        (iss_stall),
    .clr_was_pend_o (clr_was_pend)
  );

  assign bus.Iss_Stall = iss_stall;
  assign bus.Reg_Rd    = bus.Iss_Valid & ~iss_stall;

  // LSU wins unless the ALU has already lost STARVE_MAX consecutive cycles.
  always_comb begin
    sel = REQ_NONE;
    if (bus.Lsu_Wb_Valid && !(bus.Alu_Wb_Valid && (starve_q == 3'(STARVE_MAX))))
      sel = REQ_LSU;
    else if (bus.Alu_Wb_Valid)
      sel = REQ_ALU;
  end

  assign bus.Alu_Wb_Ready = (sel == REQ_ALU);
  assign bus.Lsu_Wb_Ready = (sel == REQ_LSU);

  // Writes to x0 are accepted but never reach the register file.
  always_comb begin
    win_rd   = bus.Alu_Wb_Rd;
    win_data = bus.Alu_Wb_Data;
    if (sel == REQ_LSU) begin
      win_rd   = bus.Lsu_Wb_Rd;
      win_data = bus.Lsu_Wb_Data;
    end
    reg_wr_d = (sel != REQ_NONE) && (win_rd != ZERO_REG);
    rd_wr_d  = reg_wr_d ? win_rd   : rd_wr_q;
    rd_in_d  = reg_wr_d ? win_data : rd_in_q;
    starve_d = (bus.Alu_Wb_Valid && (sel != REQ_ALU)) ? starve_q + 3'd1 : 3'd0;
    wb_err_d = reg_wr_q & ~clr_was_pend;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      starve_q <= '0;
      reg_wr_q <= 1'b0;
      rd_wr_q  <= '0;
      rd_in_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      reg_wr_q <= reg_wr_d;
      rd_wr_q  <= rd_wr_d;
      rd_in_q  <= rd_in_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign bus.Reg_Wr = reg_wr_q;
  assign bus.Rd_Wr  = rd_wr_q;
  assign bus.Rd_In  = rd_in_q;
  assign bus.Wb_Err = wb_err_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized and directed bench for regfile_wb_ctrl against a behavioural model.
module tb_regfile_wb_ctrl;
  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 3;

  logic CLK = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  regfile_wb_ctrl_if #(.XLEN(XLEN)) bus ();

  regfile_wb_ctrl #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Model: set of registers awaiting a write, ALU consecutive-loss count, output register.
  bit        m_pend [32];
  int        m_wait;
  bit        m_wr;
  int        m_rd;
  bit [31:0] m_data;
  bit        m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit alu_wins();
    return bus.Alu_Wb_Valid && (!bus.Lsu_Wb_Valid || m_wait == STARVE_MAX);
  endfunction

  function automatic bit exp_stall();
    return bus.Iss_Valid && (m_pend[bus.Iss_Rs1] || m_pend[bus.Iss_Rs2] ||
                             (bus.Iss_Rd_En && m_pend[bus.Iss_Rd]));
  endfunction

  task automatic sample();
    bit ag, lg;
    @(negedge CLK);
    ag = alu_wins();
    lg = bus.Lsu_Wb_Valid && !ag;
    chk("stall",   bus.Iss_Stall,    exp_stall());
    chk("reg_rd",  bus.Reg_Rd,       bus.Iss_Valid && !exp_stall());
    chk("alu_rdy", bus.Alu_Wb_Ready, ag);
    chk("lsu_rdy", bus.Lsu_Wb_Ready, lg);
    chk("reg_wr",  bus.Reg_Wr,       m_wr);
    chk("wb_err",  bus.Wb_Err,       m_err);
    if (m_wr) begin
      chk("rd_wr", 32'(bus.Rd_Wr), m_rd);
      chk("rd_in", bus.Rd_In,      m_data);
    end
  endtask

  task automatic advance();
    bit        n_pend [32];
    bit        ag, lg, n_wr, n_err;
    int        n_rd, n_wait, wrd;
    bit [31:0] n_data, wdat;
    ag = alu_wins();
    lg = bus.Lsu_Wb_Valid && !ag;
    n_pend = m_pend;
    n_err  = m_wr && !m_pend[m_rd];
    if (m_wr) n_pend[m_rd] = 1'b0;
    if (bus.Iss_Valid && !exp_stall() && bus.Iss_Rd_En && bus.Iss_Rd != 0)
      n_pend[bus.Iss_Rd] = 1'b1;
    wrd  = ag ? int'(bus.Alu_Wb_Rd) : int'(bus.Lsu_Wb_Rd);
    wdat = ag ? bus.Alu_Wb_Data : bus.Lsu_Wb_Data;
    n_wr   = (ag || lg) && wrd != 0;
    n_rd   = n_wr ? wrd  : m_rd;
    n_data = n_wr ? wdat : m_data;
    n_wait = (bus.Alu_Wb_Valid && !ag) ? m_wait + 1 : 0;
    @(posedge CLK);
    #1;
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_wait = 0; m_wr = 0; m_rd = 0; m_data = '0; m_err = 0;
    end else begin
      m_pend = n_pend; m_wait = n_wait; m_wr = n_wr;
      m_rd = n_rd; m_data = n_data; m_err = n_err;
    end
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle();
    bus.Iss_Valid = 0; bus.Iss_Rs1 = 0; bus.Iss_Rs2 = 0; bus.Iss_Rd = 0; bus.Iss_Rd_En = 0;
    bus.Alu_Wb_Valid = 0; bus.Alu_Wb_Rd = 0; bus.Alu_Wb_Data = '0;
    bus.Lsu_Wb_Valid = 0; bus.Lsu_Wb_Rd = 0; bus.Lsu_Wb_Data = '0;
  endtask

  task automatic issue(input bit v, input int rs1, input int rs2, input int rd, input bit en);
    bus.Iss_Valid = v; bus.Iss_Rs1 = 5'(rs1); bus.Iss_Rs2 = 5'(rs2);
    bus.Iss_Rd = 5'(rd); bus.Iss_Rd_En = en;
  endtask

  initial begin
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wait = 0; m_wr = 0; m_rd = 0; m_data = '0; m_err = 0;
    idle();
    rst = 1'b1;
    advance();
    advance();
    sample();
    chk("rst_reg_wr", bus.Reg_Wr, 0);
    chk("rst_rd_wr",  32'(bus.Rd_Wr), 0);
    chk("rst_rd_in",  bus.Rd_In, 0);
    chk("rst_wb_err", bus.Wb_Err, 0);
    advance();
    rst = 1'b0;

    // RAW on x5 held until the ALU writeback commits
    issue(1, 0, 0, 5, 1); tick();
    issue(1, 5, 0, 0, 0); sample();
    chk("raw_stall", bus.Iss_Stall, 1); chk("raw_reg_rd", bus.Reg_Rd, 0); advance();
    tick();
    bus.Alu_Wb_Valid = 1; bus.Alu_Wb_Rd = 5; bus.Alu_Wb_Data = 32'h0000_1234; tick();
    bus.Alu_Wb_Valid = 0; sample();
    chk("raw_wr", bus.Reg_Wr, 1); chk("raw_rdwr", 32'(bus.Rd_Wr), 5);
    chk("raw_still", bus.Iss_Stall, 1); advance();
    sample(); chk("raw_clear", bus.Iss_Stall, 0); chk("raw_go", bus.Reg_Rd, 1); advance();
    idle(); tick();

    // Both requesters continuously valid: LSU,LSU,LSU,ALU repeating
    bus.Alu_Wb_Valid = 1; bus.Alu_Wb_Rd = 1; bus.Alu_Wb_Data = 32'h1111_0001;
    bus.Lsu_Wb_Valid = 1; bus.Lsu_Wb_Rd = 2; bus.Lsu_Wb_Data = 32'h2222_0002;
    for (int k = 0; k < 8; k++) begin
      sample();
      chk("starve_alu", bus.Alu_Wb_Ready, (k % 4) == 3);
      chk("starve_lsu", bus.Lsu_Wb_Ready, (k % 4) != 3);
      advance();
    end
    idle(); tick(); tick(); tick();

    // LSU write to x0 is granted but never written
    bus.Lsu_Wb_Valid = 1; bus.Lsu_Wb_Rd = 0; bus.Lsu_Wb_Data = 32'hDEAD_BEEF;
    sample(); chk("x0_rdy", bus.Lsu_Wb_Ready, 1); advance();
    idle(); sample(); chk("x0_wr", bus.Reg_Wr, 0); advance();
    sample(); chk("x0_err", bus.Wb_Err, 0); advance();

    // ALU write to non-pending x7 flags an error one cycle after the commit
    bus.Alu_Wb_Valid = 1; bus.Alu_Wb_Rd = 7; bus.Alu_Wb_Data = 32'hA5A5_0007; tick();
    idle(); sample();
    chk("np_wr", bus.Reg_Wr, 1); chk("np_rd", 32'(bus.Rd_Wr), 7);
    chk("np_data", bus.Rd_In, 32'hA5A5_0007); chk("np_noerr", bus.Wb_Err, 0); advance();
    sample(); chk("np_err", bus.Wb_Err, 1); advance();
    sample(); chk("np_err_end", bus.Wb_Err, 0); advance();

    // WAW on x9
    issue(1, 0, 0, 9, 1); tick();
    sample(); chk("waw_stall", bus.Iss_Stall, 1); advance();
    bus.Lsu_Wb_Valid = 1; bus.Lsu_Wb_Rd = 9; bus.Lsu_Wb_Data = 32'h0000_0099; tick();
    bus.Lsu_Wb_Valid = 0; sample(); chk("waw_hold", bus.Iss_Stall, 1); advance();
    sample(); chk("waw_go", bus.Iss_Stall, 0); advance();
    idle(); tick();

    // Reset with x3/x4 pending and a write in the output register
    issue(1, 0, 0, 3, 1); tick();
    issue(1, 0, 0, 4, 1);
    bus.Alu_Wb_Valid = 1; bus.Alu_Wb_Rd = 10; bus.Alu_Wb_Data = 32'h0000_0010; tick();
    idle(); rst = 1'b1;
    bus.Lsu_Wb_Valid = 1; bus.Lsu_Wb_Rd = 11; bus.Lsu_Wb_Data = 32'h0000_0011;
    sample(); chk("mr_wr_pre", bus.Reg_Wr, 1); chk("mr_lsu_rdy", bus.Lsu_Wb_Ready, 1); advance();
    idle(); rst = 1'b0; issue(1, 3, 4, 0, 0);
    sample();
    chk("mr_wr", bus.Reg_Wr, 0); chk("mr_rdwr", 32'(bus.Rd_Wr), 0);
    chk("mr_rdin", bus.Rd_In, 0); chk("mr_err", bus.Wb_Err, 0);
    chk("mr_stall", bus.Iss_Stall, 0);
    advance();
    idle(); tick();

    // Random traffic over a small register window to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      issue($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1));
      bus.Alu_Wb_Valid = ($urandom_range(0, 2) != 0);
      bus.Alu_Wb_Rd    = 5'($urandom_range(0, 7));
      bus.Alu_Wb_Data  = $urandom;
      bus.Lsu_Wb_Valid = ($urandom_range(0, 2) != 0);
      bus.Lsu_Wb_Rd    = 5'($urandom_range(0, 7));
      bus.Lsu_Wb_Data  = $urandom;
      tick();
    end
    rst = 1'b0;
    idle(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
